pulse_cdc_checker: RTL
======================

# pulse_cdc_checker

Single-clock monitor that sits downstream of a `pulse_cdc` loopback pair. It takes the originating pulse and the pulse returned after the round trip, both in the same domain. It counts sent and received pulses, timestamps each outstanding pulse, measures round-trip latency, and flags lost, spurious or overflowing pulses. Its outputs feed the ChipScope ILA trigger bus and replace ad-hoc counters in the board top level.

## Interface
Parameters:
- `CNT_W`, 64: width of the sent/received pulse counters.
- `TS_W`, 16: width of the free-running timestamp and of all latency values.
- `DEPTH`, 8: number of outstanding pulses tracked. Power of two, ≥2.
- `TIMEOUT`, 256: age in cycles at which an outstanding pulse is declared lost. Must satisfy 1 ≤ TIMEOUT < 2^TS_W.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `clr`, in, 1: synchronous clear of statistics, errors and tracking state.
- `pulse_snd`, in, 1: single-cycle pulse entering the CDC path.
- `pulse_rcv`, in, 1: single-cycle pulse returned from the CDC path.
- `count_snd`, out, CNT_W: pulses sent.
- `count_rcv`, out, CNT_W: pulses received.
- `outstanding`, out, $clog2(DEPTH)+1: current tracking FIFO occupancy.
- `lat_valid`, out, 1: one-cycle strobe indicating that `lat_last` was updated.
- `lat_last`, out, TS_W: latest measured round-trip latency.
- `lat_min`, out, TS_W: minimum latency measured since reset or clear.
- `lat_max`, out, TS_W: maximum latency measured since reset or clear.
- `err_overflow`, out, 1: sticky. A send arrived while the FIFO was full.
- `err_underflow`, out, 1: sticky. A receive arrived with nothing outstanding.
- `err_timeout`, out, 1: sticky. An outstanding pulse aged out.
- `err_any`, out, 1: OR of the three sticky error flags, registered.

## Operation
- `ts` is a free-running TS_W counter. It wraps modulo 2^TS_W and is not affected by `clr`.
- On `pulse_snd`:
  - `count_snd` increments.
  - `ts` is pushed into the tracking FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the push is dropped and `err_overflow` is set. `count_snd` still increments.
- On `pulse_rcv`:
  - `count_rcv` increments.
  - If the FIFO is non-empty at cycle start, the head is popped. Latency is `ts - head` modulo 2^TS_W.
  - If the FIFO is empty at cycle start, `err_underflow` is set. A same-cycle push does not satisfy the receive.
- Simultaneous send and receive: the pop and the push both take effect and occupancy is unchanged. This also holds when the FIFO is full, so no overflow is flagged.
- Timeout: when the FIFO is non-empty, no receive occurs, and `ts - head` ≥ TIMEOUT, the head is discarded and `err_timeout` is set. At most one discard occurs per cycle. A receive in the same cycle takes priority over the timeout check.
- Latency statistics:
  - `lat_min` resets to all-ones and `lat_max` resets to 0.
  - Both update on every measured latency.
  - Both saturate implicitly because they are bounded by TS_W.
- Counters wrap modulo 2^CNT_W.
- `clr` has priority over everything in the same cycle. Any pulses presented with it are ignored.
- Reset values: every output is 0 except `lat_min`, which resets to all-ones. The FIFO is empty and `ts` is 0.

## Timing
- All outputs are registered.
- `count_*`, `outstanding` and the error flags reflect a pulse on the cycle after it is sampled.
- `lat_valid` asserts exactly 1 cycle after the `pulse_rcv` sample, together with the new `lat_last`.
- `lat_min` and `lat_max` update on that same cycle.
- `err_any` lags the individual flags by 1 cycle.
- `clr` takes effect on the next edge. Statistics and flags equal their reset values 1 cycle after `clr` is sampled.
- Asserting `rst` mid-operation clears everything asynchronously. There is no recovery handshake, and the first pulse after release is tracked normally.
- Throughput: one send and one receive per cycle, sustained.

## Structure
- Shared header `pulse_cdc_defs.vh` holds the default `CNT_W`, `TS_W`, `DEPTH` and `TIMEOUT` values, and the error-bit index constants used when packing into `trig0`.
- Sub-module `ts_fifo` is a DEPTH×TS_W synchronous FIFO with simultaneous push/pop, `full`, `empty`, `count` and `head` outputs, and a synchronous flush. It uses the same `clk`/`rst`.
- The top module contains the timestamp counter, the statistics registers, the error logic and the output registers.

## Test plan
- Single send at ts=10, receive at ts=15: `lat_valid` pulses at ts=16 with `lat_last=5`. Then `lat_min=lat_max=5`, both counts are 1, `outstanding=0`, and no errors are set.
- Send every 8 cycles with a 12-cycle loopback, 100 pulses: `count_snd=count_rcv=100`, `outstanding` stays within 1..2, `lat_min=lat_max=12`, and `err_any=0`.
- DEPTH=8, 9 sends with no receive: `err_overflow=1` after the 9th, `outstanding=8`, `count_snd=9`. Same-cycle send and receive at full: no overflow, occupancy unchanged.
- Receive with the FIFO empty, plus a receive coinciding with the first send: `err_underflow=1` in both cases, `count_rcv` increments, and `lat_valid` stays 0.
- Send at ts=100 and never receive: `err_timeout=1` on the cycle after ts=356, `outstanding=0`, and a subsequent late receive raises `err_underflow`.
- Wrap and clear:
  - Send at ts=0xFFFE and receive at ts=0x0003: `lat_last=5`.
  - `clr` asserted with a coincident send: all statistics return to their reset values and `outstanding=0`.
  - `rst` asserted mid-stream: all outputs go to their reset values immediately.

Source files
------------

// File: rtl/pulse_cdc_checker_pkg.sv
// pulse_cdc_checker_pkg: default parameters, error-bit layout and packing helper for the pulse CDC checker
package pulse_cdc_checker_pkg;

    localparam int DEF_CNT_W   = 64;
    localparam int DEF_TS_W    = 16;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 256;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    localparam int ERR_TMO = 2;
    localparam int ERR_W   = 3;

    function automatic logic [ERR_W-1:0] pack_err(input logic ovf, input logic udf, input logic tmo);
        logic [ERR_W-1:0] e;
        e          = '0;
        e[ERR_OVF] = ovf;
        e[ERR_UDF] = udf;
        e[ERR_TMO] = tmo;
        return e;
    endfunction

endpackage

// File: rtl/pulse_cdc_checker_ts_fifo.sv
// pulse_cdc_checker_ts_fifo: DEPTH x W timestamp FIFO with simultaneous push/pop and synchronous flush
module pulse_cdc_checker_ts_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when a pop frees the head slot in the same cycle
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
        count_d  = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pulse_cdc_checker.sv
// pulse_cdc_checker: counts, timestamps and latency-checks pulses looped back through a pulse CDC pair
module pulse_cdc_checker
    import pulse_cdc_checker_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TS_W    = DEF_TS_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     pulse_snd,
    input  logic                     pulse_rcv,
    output logic [CNT_W-1:0]         count_snd,
    output logic [CNT_W-1:0]         count_rcv,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     lat_valid,
    output logic [TS_W-1:0]          lat_last,
    output logic [TS_W-1:0]          lat_min,
    output logic [TS_W-1:0]          lat_max,
    output logic                     err_overflow,
    output logic                     err_underflow,
    output logic                     err_timeout,
    output logic                     err_any
);

    logic [TS_W-1:0]        ts_q, ts_d;
    logic [CNT_W-1:0]       count_snd_q, count_snd_d, count_rcv_q, count_rcv_d;
    logic                   lat_valid_q, lat_valid_d;
    logic [TS_W-1:0]        lat_last_q, lat_last_d, lat_min_q, lat_min_d, lat_max_q, lat_max_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   err_any_q, err_any_d;
    logic                   fifo_full, fifo_empty, push, pop, rcv_pop, tmo_pop;
    logic [TS_W-1:0]        fifo_head, age;
    logic [$clog2(DEPTH):0] fifo_count;

    pulse_cdc_checker_ts_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr),
        .push  (push),
        .pop   (pop),
        .din   (ts_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Pop/push decisions, statistics and sticky error next-state; clr overrides every pulse
    always_comb begin
        ts_d        = ts_q + 1'b1;
        age         = ts_q - fifo_head;
        rcv_pop     = pulse_rcv & ~fifo_empty;
        tmo_pop     = ~fifo_empty & ~pulse_rcv & (age >= TS_W'(TIMEOUT));
        pop         = ~clr & (rcv_pop | tmo_pop);
        push        = ~clr & pulse_snd & (~fifo_full | pop);
        count_snd_d = clr ? '0 : count_snd_q + CNT_W'(pulse_snd);
        count_rcv_d = clr ? '0 : count_rcv_q + CNT_W'(pulse_rcv);
        lat_valid_d = ~clr & rcv_pop;
        lat_last_d  = clr ? '0 : (rcv_pop ? age : lat_last_q);
        lat_min_d   = clr ? '1 : ((rcv_pop && age < lat_min_q) ? age : lat_min_q);
        lat_max_d   = clr ? '0 : ((rcv_pop && age > lat_max_q) ? age : lat_max_q);
        err_d       = clr ? '0 : err_q | pack_err(pulse_snd & fifo_full & ~pop, pulse_rcv & fifo_empty, tmo_pop);
        err_any_d   = ~clr & (|err_q);
    end

    // All state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q        <= '0;
            count_snd_q <= '0;
            count_rcv_q <= '0;
            lat_valid_q <= 1'b0;
            lat_last_q  <= '0;
            lat_min_q   <= '1;
            lat_max_q   <= '0;
            err_q       <= '0;
            err_any_q   <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            count_snd_q <= count_snd_d;
            count_rcv_q <= count_rcv_d;
            lat_valid_q <= lat_valid_d;
            lat_last_q  <= lat_last_d;
            lat_min_q   <= lat_min_d;
            lat_max_q   <= lat_max_d;
            err_q       <= err_d;
            err_any_q   <= err_any_d;
        end
    end

    assign count_snd     = count_snd_q;
    assign count_rcv     = count_rcv_q;
    assign outstanding   = fifo_count;
    assign lat_valid     = lat_valid_q;
    assign lat_last      = lat_last_q;
    assign lat_min       = lat_min_q;
    assign lat_max       = lat_max_q;
    assign err_overflow  = err_q[ERR_OVF];
    assign err_underflow = err_q[ERR_UDF];
    assign err_timeout   = err_q[ERR_TMO];
    assign err_any       = err_any_q;

endmodule
